// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one step per clock.
// Optional two's-complement input and sign output when BIN2BCD_SIGNED_EN is defined.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BIN2BCD_SIGNED_EN
  output logic                  ovf,
  output logic                  sign
`else
  output logic                  ovf
`endif
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    work_q, work_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic             sticky_q, sticky_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    work_step;
  logic [BIN_W-1:0] shreg_step;
  logic             lost;
  logic             sticky_step;
  logic [BIN_W-1:0] mag;
  logic             accept;
  logic             release_res;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid & in_ready;
  assign release_res = out_valid & out_ready;
  assign bcd_out     = bcd_q;
  assign ovf         = ovf_q;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_cap_q, sign_cap_d;
  logic sign_q, sign_d;

  // Magnitude of the two's-complement input; the most negative value maps cleanly.
  always_comb begin
    mag = bin_in;
    if (bin_in[BIN_W-1]) begin
      mag = ~bin_in + 1'b1;
    end
  end

  assign sign = sign_q;
`else
  // Unsigned input is its own magnitude.
  always_comb begin
    mag = bin_in;
  end
`endif

  // Add-3 correction on every working digit above 4.
  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] > 4'd4) begin
        adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end else begin
        adj[4*k +: 4] = work_q[4*k +: 4];
      end
    end
  end

  // One double-dabble shift; the bit leaving the top digit marks overflow.
  always_comb begin
    lost        = adj[BW-1];
    {work_step, shreg_step} = {adj[BW-2:0], shreg_q, 1'b0};
    sticky_step = sticky_q | lost;
  end

  // Next-state, datapath and result-register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    shreg_d  = shreg_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    sign_cap_d = sign_cap_q;
    sign_d     = sign_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d  = mag;
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          state_d  = CONV;
`ifdef BIN2BCD_SIGNED_EN
          sign_cap_d = bin_in[BIN_W-1];
`endif
        end
      end
      CONV: begin
        work_d   = work_step;
        shreg_d  = shreg_step;
        sticky_d = sticky_step;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          ovf_d   = sticky_step;
          bcd_d   = sticky_step ? {DIGITS{4'h9}} : work_step;
`ifdef BIN2BCD_SIGNED_EN
          sign_d = sign_cap_q;
`endif
        end
      end
      DONE: begin
        if (release_res) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      shreg_q  <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      shreg_q  <= shreg_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  // Sign capture at accept and presentation at result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_cap_q <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      sign_cap_q <= sign_cap_d;
      sign_q     <= sign_d;
    end
  end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and table-driven bench for bin2bcd_seq.
// Covers 8x3, 8x2 and 16x5 instances side by side.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SIGNED_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] iv = '0;
  logic [2:0] ir;
  logic [2:0] ovl;
  logic [2:0] ordy = '0;
  logic [2:0] fl;
  logic [2:0] sg;
  logic [7:0]  bin_a = '0;
  logic [7:0]  bin_b = '0;
  logic [15:0] bin_c = '0;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .bin_in(bin_a), .out_valid(ovl[0]), .out_ready(ordy[0]),
`ifdef BIN2BCD_SIGNED_EN
    .bcd_out(bcd_a), .ovf(fl[0]), .sign(sg[0])
`else
    .bcd_out(bcd_a), .ovf(fl[0])
`endif
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .bin_in(bin_b), .out_valid(ovl[1]), .out_ready(ordy[1]),
`ifdef BIN2BCD_SIGNED_EN
    .bcd_out(bcd_b), .ovf(fl[1]), .sign(sg[1])
`else
    .bcd_out(bcd_b), .ovf(fl[1])
`endif
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .bin_in(bin_c), .out_valid(ovl[2]), .out_ready(ordy[2]),
`ifdef BIN2BCD_SIGNED_EN
    .bcd_out(bcd_c), .ovf(fl[2]), .sign(sg[2])
`else
    .bcd_out(bcd_c), .ovf(fl[2])
`endif
  );

`ifndef BIN2BCD_SIGNED_EN
  assign sg = '0;
`endif

  typedef struct {
    int          s;
    logic [31:0] v;
    logic [39:0] b;
    logic        f;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int wid(input int s);
    return (s == 2) ? 16 : 8;
  endfunction

  function automatic logic [39:0] get_bcd(input int s);
    case (s)
      0:       return {28'b0, bcd_a};
      1:       return {32'b0, bcd_b};
      default: return {20'b0, bcd_c};
    endcase
  endfunction

  function automatic logic exp_sign(input int s, input logic [31:0] v);
    return SE & v[wid(s)-1];
  endfunction

  // Decimal reference: magnitude, then digits by repeated division.
  function automatic logic [39:0] ref_bcd(input int w, input int d,
                                          input logic [31:0] v,
                                          output logic of);
    longint m;
    logic [39:0] r;
    m = longint'(v & ((32'h1 << w) - 1));
    if (SE && v[w-1]) m = (longint'(1) << w) - m;
    r = '0;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    of = (m != 0);
    if (of) begin
      for (int k = 0; k < d; k++) r[4*k +: 4] = 4'h9;
    end
    return r;
  endfunction

  task automatic conv(input int s, input logic [31:0] v,
                      output logic [39:0] b, output logic f,
                      output logic sgn, output int lat);
    @(negedge clk);
    iv[s] = 1'b1;
    case (s)
      0:       bin_a = v[7:0];
      1:       bin_b = v[7:0];
      default: bin_c = v[15:0];
    endcase
    @(posedge clk);
    #1 iv[s] = 1'b0;
    lat = 0;
    while (!ovl[s] && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    b = get_bcd(s);
    f = fl[s];
    sgn = sg[s];
    ordy[s] = 1'b1;
    @(posedge clk);
    #1 ordy[s] = 1'b0;
  endtask

  initial begin
    logic [39:0] b;
    logic [39:0] eb;
    logic f, ef, sgn;
    int lat;
    bit ok;
    logic [31:0] v;

    tv.push_back('{0, 32'd0,   40'h000, 1'b0});
    tv.push_back('{0, 32'd100, 40'h100, 1'b0});
    tv.push_back('{0, 32'd127, 40'h127, 1'b0});
    tv.push_back('{0, 32'd128, 40'h128, 1'b0});
`ifdef BIN2BCD_SIGNED_EN
    tv.push_back('{0, 32'd255, 40'h001, 1'b0});
    tv.push_back('{2, 32'd65535, 40'h00001, 1'b0});
`else
    tv.push_back('{0, 32'd255, 40'h255, 1'b0});
    tv.push_back('{2, 32'd65535, 40'h65535, 1'b0});
`endif
    tv.push_back('{1, 32'd123, 40'h99, 1'b1});
    tv.push_back('{1, 32'd99,  40'h99, 1'b0});
    tv.push_back('{1, 32'd100, 40'h99, 1'b1});
    tv.push_back('{2, 32'd0,     40'h00000, 1'b0});
    tv.push_back('{2, 32'd9999,  40'h09999, 1'b0});
    tv.push_back('{2, 32'd10000, 40'h10000, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ir), 64'h7);
    chk("rst_out_valid", 64'(ovl), 64'h0);
    chk("rst_ovf", 64'(fl), 64'h0);
    chk("rst_sign", 64'(sg), 64'h0);
    chk("rst_bcd_a", 64'(bcd_a), 64'h0);
    chk("rst_bcd_c", 64'(bcd_c), 64'h0);
    rst = 1'b0;

    foreach (tv[i]) begin
      conv(tv[i].s, tv[i].v, b, f, sgn, lat);
      chk($sformatf("tbl%0d_bcd", i), 64'(b), 64'(tv[i].b));
      chk($sformatf("tbl%0d_ovf", i), 64'(f), 64'(tv[i].f));
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(wid(tv[i].s)));
      chk($sformatf("tbl%0d_sign", i), 64'(sgn),
          64'(exp_sign(tv[i].s, tv[i].v)));
    end

    // Back-pressure with 42: result held, input side locked out.
    @(negedge clk);
    iv[0] = 1'b1;
    bin_a = 8'd42;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    lat = 0;
    while (!ovl[0] && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("bp_lat", 64'(lat), 64'd8);
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      iv[0] = ~iv[0];
      bin_a = 8'($urandom);
      @(posedge clk);
      #1;
      if (!ovl[0] || ir[0] || bcd_a != 12'h042 || fl[0]) ok = 1'b0;
    end
    chk("bp_hold", 64'(ok), 64'd1);
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 ordy[0] = 1'b0;
    chk("bp_clear", 64'(ovl[0]), 64'd0);
    chk("bp_in_ready", 64'(ir[0]), 64'd1);
    chk("bp_retain", 64'(bcd_a), 64'h042);

    // Reset on the 4th step edge of 200.
    @(negedge clk);
    iv[0] = 1'b1;
    bin_a = 8'd200;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    chk("mid_busy", 64'(ir[0]), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_in_ready", 64'(ir[0]), 64'd1);
    chk("mid_out_valid", 64'(ovl[0]), 64'd0);
    chk("mid_bcd", 64'(bcd_a), 64'h0);
    conv(0, 32'd17, b, f, sgn, lat);
    chk("post_bcd", 64'(b), 64'h017);
    chk("post_lat", 64'(lat), 64'd8);
    chk("post_ovf", 64'(f), 64'd0);

    // 16-bit random sweep against the decimal model.
    for (int n = 0; n < 1000; n++) begin
      v = 32'($urandom_range(0, 65535));
      eb = ref_bcd(16, 5, v, ef);
      conv(2, v, b, f, sgn, lat);
      chk($sformatf("sw_bcd_%0d", v), 64'(b), 64'(eb));
      chk($sformatf("sw_ovf_%0d", v), 64'(f), 64'(ef));
      chk($sformatf("sw_lat_%0d", v), 64'(lat), 64'd16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised sequential binary-to-BCD converter for the modem's display and telemetry paths. It accepts a BIN_W-bit binary word over a valid/ready handshake and runs one double-dabble step (add-3 and shift) per clock. It returns DIGITS packed BCD digits with an overflow/saturation flag over a second valid/ready handshake. It generalises the fixed 8-bit, 2-digit free-running converter: widths and digit count are configurable, conversion is started on demand, the result is back-pressurable, and overflow is detected.

## Interface
Parameters:
- BIN_W, 8, binary input width; legal range 2..32.
- DIGITS, 3, number of BCD output digits; legal range 1..10.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  bin_in is presented.
- in_ready  out  1  block can accept a word; high only in IDLE.
- bin_in  in  BIN_W  binary word, sampled on the accept edge (in_valid & in_ready).
- out_valid  out  1  bcd_out/ovf hold a fresh result.
- out_ready  in  1  consumer accepts the result.
- bcd_out  out  4*DIGITS  packed BCD; digit 0 (units) in [3:0], digit k in [4k+3:4k].
- ovf  out  1  value did not fit in DIGITS digits; bcd_out is saturated to all 9s.
- sign  out  1  sign of the result; present only with BIN2BCD_SIGNED_EN (see Configuration).

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load the magnitude of bin_in into the shift register, clear the BCD working register and the sticky overflow bit, set step counter = 0, go to CONV.
- CONV:
  - in_ready=0.
  - Each edge, in one cycle: every 4-bit working digit > 4 gets +3 (modulo 16); then {bcd_work, shift_reg} shifts left by 1.
  - If the bit leaving the top of bcd_work is 1, set sticky overflow.
  - Counter increments. When the counter reaches BIN_W-1 on an edge, that edge performs the last step and the FSM goes to DONE.
- Result load:
  - On the CONV-to-DONE edge, bcd_out gets the final working value, or all 4'h9 digits if overflow was set (including overflow on the last step). ovf is loaded on the same edge.
- DONE:
  - out_valid=1; bcd_out, ovf and sign are stable.
  - On out_valid & out_ready, go to IDLE.
- Retention: bcd_out, ovf and sign keep their value after the handshake until the next result load.
- Inputs ignored: in_valid is ignored outside IDLE; out_ready is ignored outside DONE.
- Width rules:
  - Working register is 4*DIGITS bits and shift register is BIN_W bits.
  - DIGITS below ceil(BIN_W*log10(2)) is legal; overflow is then reported per word, not rejected.
- Reset: rst=1 on any edge (including mid-CONV or in DONE) gives:
  - state IDLE, in_ready=1, out_valid=0;
  - bcd_out=0, ovf=0, sign=0;
  - counter and working registers 0.
  - Any conversion in flight is discarded.

## Timing
- Accept edge A (in_valid & in_ready high): state becomes CONV after A; in_ready is low from the cycle after A.
- Steps occur on edges A+1 .. A+BIN_W. out_valid rises after edge A+BIN_W, so latency from the accept edge to out_valid is BIN_W cycles.
- The earliest out_ready handshake is on edge A+BIN_W+1. in_ready returns high the cycle after the output handshake.
- Minimum period per word is BIN_W+2 cycles; there is no overlap between output and input handshakes.
- out_valid stays high indefinitely while out_ready=0.

## Configuration
- BIN2BCD_SIGNED_EN defined:
  - bin_in is two's complement; on the accept edge the shift register loads |bin_in|, and a sign register captures bin_in[BIN_W-1].
  - The sign register is output on sign, updated on the result-load edge and reset to 0.
  - -2^(BIN_W-1) converts as magnitude 2^(BIN_W-1) with no error.
- BIN2BCD_SIGNED_EN undefined:
  - bin_in is unsigned and the sign port does not exist.
  - The block carries no sign logic.

## Test plan
- BIN_W=8, DIGITS=3, unsigned: in_valid with bin_in=255 and out_ready=1 -> out_valid exactly 8 cycles after accept, bcd_out=12'h255, ovf=0; repeat for 0 -> 12'h000 and 100 -> 12'h100.
- BIN_W=8, DIGITS=2: bin_in=123 -> ovf=1, bcd_out=8'h99; then bin_in=99 -> ovf=0, bcd_out=8'h99; then bin_in=100 -> ovf=1.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid with bin_in=42 -> out_valid, bcd_out=12'h042 held stable and in_ready=0 throughout. Toggling in_valid/bin_in meanwhile has no effect; the result clears one cycle after out_ready=1.
- Reset mid-conversion: assert rst on the 4th step edge of bin_in=200 -> next cycle in_ready=1, out_valid=0, bcd_out=0. A subsequent 17 converts to 12'h017 with normal latency.
- BIN_W=16, DIGITS=5: random sweep of 1000 values including 0, 9999, 10000 and 65535 -> bcd_out equals a decimal reference model, latency is 16 cycles, ovf=0.
- With BIN2BCD_SIGNED_EN, BIN_W=8, DIGITS=3: -128 -> sign=1, 12'h128; -1 -> sign=1, 12'h001; 127 -> sign=0, 12'h127.
